muldiv_seq: RTL and testbench

Sequential multiply/divide unit for the MIPS datapath, owning the architectural HI/LO registers. It executes MULT, MULTU, DIV and DIVU iteratively, one bit per clock, instead of using wide combinational `*` and `/` operators. It sits beside the single-cycle ALU and stalls the pipeline through `busy`. HI/LO are also writable directly for MTHI/MTLO.

---
 rtl/muldiv_seq_pkg.sv | 32 +++
 rtl/muldiv_seq_if.sv | 34 +++
 rtl/muldiv_seq_step.sv | 46 ++++
 rtl/muldiv_seq.sv | 149 ++++++++++++++
 tb/tb_muldiv_seq.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared definitions for the sequential multiply/divide unit.
// Holds the register width, the op encodings carried on the op bus, the
// FSM state encodings and small helpers that decode an op into its class.
package muldiv_seq_pkg;

  localparam int REG_WIDTH = 32;

  // op encodings as presented on the op input
  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_SIGN = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

  // Bit 1 of the op selects divide, bit 0 selects signed operands.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/result bundle between the pipeline and muldiv_seq.
//   start, op, op_a, op_b : launch an operation (sampled only when idle)
//   wr_hi, wr_lo, wr_data : direct HI/LO writes (MTHI/MTLO)
//   busy, done            : in-flight status and one-cycle completion pulse
//   hi, lo, div_by_zero   : architectural HI/LO and last-divide-by-zero flag
// master = pipeline side, slave = the multiply/divide unit.
interface muldiv_seq_if #(
  parameter int WIDTH = muldiv_seq_pkg::REG_WIDTH
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, op_a, op_b, wr_hi, wr_lo, wr_data,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, op_a, op_b, wr_hi, wr_lo, wr_data,
    output busy, done, hi, lo, div_by_zero
  );

endinterface

// File: rtl/muldiv_seq_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   acc      in  2*WIDTH : running accumulator
//   operand  in  WIDTH   : multiplicand (multiply) or divisor (divide)
//   is_div   in  1       : 1 = restoring-divide step, 0 = shift-add step
//   acc_next out 2*WIDTH : accumulator after this iteration
// Multiply layout: {partial product high, remaining multiplier bits}; the
// low bit decides the add, then everything shifts right one place.
// Divide layout: {partial remainder, remaining dividend bits}; shift left,
// trial-subtract the divisor, and shift the quotient bit in at the bottom.
module muldiv_step #(
  parameter int WIDTH = muldiv_seq_pkg::REG_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] diff_s;

  // Single iteration: conditional add+shift or trial subtract+shift.
  always_comb begin
    sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    // Remainder shifted left with the next dividend bit brought in.
    rem_sh_s = acc[2*WIDTH-1:WIDTH-1];
    // Only evaluated when rem_sh_s >= operand, so the result fits WIDTH bits.
    diff_s   = rem_sh_s[WIDTH-1:0] - operand;
    acc_next = acc;
    if (is_div) begin
      if (rem_sh_s >= {1'b0, operand}) begin
        acc_next = {diff_s, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc[0]) begin
        acc_next = {sum_s, acc[WIDTH-1:1]};
      end else begin
        acc_next = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : muldiv_seq_if slave port (request, MTHI/MTLO, status, HI/LO)
// One datapath bit per clock: IDLE -> RUN (WIDTH cycles) -> SIGN -> DONE.
// Signed ops run on magnitudes; signs are reapplied in SIGN.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  md_state_e          state_r;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   operand_r;
  logic [WIDTH-1:0]   orig_a_r;
  logic               is_div_r;
  logic               sign_a_r;
  logic               sign_b_r;
  logic               dz_r;
  logic               busy_r;
  logic               done_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               start_div_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;
  logic [2*WIDTH-1:0] step_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   hi_res_s;
  logic [WIDTH-1:0]   lo_res_s;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_r),
    .operand  (operand_r),
    .is_div   (is_div_r),
    .acc_next (step_s)
  );

  // Operand decode at launch: magnitudes only for the signed ops.
  always_comb begin
    start_div_s = op_is_div(bus.op);
    a_neg_s     = op_is_signed(bus.op) & bus.op_a[WIDTH-1];
    b_neg_s     = op_is_signed(bus.op) & bus.op_b[WIDTH-1];
    abs_a_s     = a_neg_s ? (-bus.op_a) : bus.op_a;
    abs_b_s     = b_neg_s ? (-bus.op_b) : bus.op_b;
  end

  // Sign fixup of the finished accumulator into HI/LO values.
  always_comb begin
    prod_s   = (sign_a_r ^ sign_b_r) ? (-acc_r) : acc_r;
    hi_res_s = prod_s[2*WIDTH-1:WIDTH];
    lo_res_s = prod_s[WIDTH-1:0];
    if (is_div_r) begin
      if (dz_r) begin
        // Divide by zero bypasses the sign fixup entirely.
        hi_res_s = orig_a_r;
        lo_res_s = {WIDTH{1'b1}};
      end else begin
        // Most-negative / -1 falls out naturally: 0x80..0 negates to itself.
        lo_res_s = (sign_a_r ^ sign_b_r) ? (-acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
        hi_res_s = sign_a_r ? (-acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
      end
    end else begin
      hi_res_s = prod_s[2*WIDTH-1:WIDTH];
      lo_res_s = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM, iteration counter, accumulator and HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= MD_IDLE;
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      operand_r <= {WIDTH{1'b0}};
      orig_a_r  <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      sign_a_r  <= 1'b0;
      sign_b_r  <= 1'b0;
      dz_r      <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dbz_r     <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        MD_IDLE: begin
          if (bus.wr_hi) hi_r <= bus.wr_data;
          if (bus.wr_lo) lo_r <= bus.wr_data;
          if (bus.start) begin
            is_div_r  <= start_div_s;
            sign_a_r  <= a_neg_s;
            sign_b_r  <= b_neg_s;
            dz_r      <= start_div_s & (bus.op_b == {WIDTH{1'b0}});
            orig_a_r  <= bus.op_a;
            operand_r <= start_div_s ? abs_b_s : abs_a_s;
            acc_r     <= start_div_s ? {{WIDTH{1'b0}}, abs_a_s}
                                     : {{WIDTH{1'b0}}, abs_b_s};
            cnt_r     <= {CW{1'b0}};
            dbz_r     <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= MD_RUN;
          end
        end
        MD_RUN: begin
          acc_r <= step_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) state_r <= MD_SIGN;
        end
        MD_SIGN: begin
          hi_r    <= hi_res_s;
          lo_r    <= lo_res_s;
          dbz_r   <= is_div_r & dz_r;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= MD_DONE;
        end
        MD_DONE: begin
          state_r <= MD_IDLE;
        end
        default: begin
          state_r <= MD_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq (WIDTH = 32).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   lat;
  int   busy_cnt;
  logic dz_at_start;
  int   done_seen;

  muldiv_seq_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one op and wait (bounded) for done. Optionally pokes start and
  // wr_hi for one cycle in the middle of RUN.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, output int lat_o, output int busy_o,
                        output logic dz0_o);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.op_a = a; bus.op_b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 2'b00; bus.op_a = 32'h0; bus.op_b = 32'h0;
    lat_o  = 0;
    busy_o = (bus.busy === 1'b1) ? 1 : 0;
    dz0_o  = bus.div_by_zero;
    while (lat_o < 100 && bus.done !== 1'b1) begin
      if (poke && lat_o == 5) begin
        bus.start = 1'b1; bus.op = 2'b10; bus.op_a = 32'h99; bus.op_b = 32'h3;
        bus.wr_hi = 1'b1; bus.wr_data = 32'h1234;
      end else begin
        bus.start = 1'b0; bus.op = 2'b00; bus.op_a = 32'h0; bus.op_b = 32'h0;
        bus.wr_hi = 1'b0; bus.wr_data = 32'h0;
      end
      @(negedge clk);
      lat_o++;
      if (bus.busy === 1'b1) busy_o++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.op_a = 32'h0; bus.op_b = 32'h0;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'h0);
    check("reset_done", 64'(bus.done), 64'h0);
    check("reset_hi",   64'(bus.hi),   64'h0);
    check("reset_lo",   64'(bus.lo),   64'h0);
    check("reset_dbz",  64'(bus.div_by_zero), 64'h0);

    // MULTU max * max: latency and busy length
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, busy_cnt, dz_at_start);
    check("multu_latency", 64'(lat), 64'd33);
    check("multu_busy_cycles", 64'(busy_cnt), 64'd33);
    check("multu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
    check("multu_lo", 64'(bus.lo), 64'h0000_0001);
    check("multu_dbz", 64'(bus.div_by_zero), 64'h0);

    // MULT -3 * 5 = -15
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, lat, busy_cnt, dz_at_start);
    check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(bus.lo), 64'hFFFF_FFF1);

    // DIV -7 / 2 = -3 rem -1
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, lat, busy_cnt, dz_at_start);
    check("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);

    // DIVU 100 / 0
    run_op(MD_DIVU, 32'd100, 32'd0, 1'b0, lat, busy_cnt, dz_at_start);
    check("divz_latency", 64'(lat), 64'd33);
    check("divz_lo", 64'(bus.lo), 64'hFFFF_FFFF);
    check("divz_hi", 64'(bus.hi), 64'h0000_0064);
    check("divz_flag", 64'(bus.div_by_zero), 64'h1);

    // DIVU 100 / 7, flag cleared as soon as the start is accepted
    run_op(MD_DIVU, 32'd100, 32'd7, 1'b0, lat, busy_cnt, dz_at_start);
    check("divu_flag_clear", 64'(dz_at_start), 64'h0);
    check("divu_lo", 64'(bus.lo), 64'd14);
    check("divu_hi", 64'(bus.hi), 64'd2);

    // DIV most-negative / -1
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, busy_cnt, dz_at_start);
    check("divmn_lo", 64'(bus.lo), 64'h8000_0000);
    check("divmn_hi", 64'(bus.hi), 64'h0);
    check("divmn_flag", 64'(bus.div_by_zero), 64'h0);

    // MULTU 6 * 7 with start and MTHI poked mid-RUN
    run_op(MD_MULTU, 32'd6, 32'd7, 1'b1, lat, busy_cnt, dz_at_start);
    check("poke_latency", 64'(lat), 64'd33);
    check("poke_hi", 64'(bus.hi), 64'h0);
    check("poke_lo", 64'(bus.lo), 64'd42);

    // MTLO / MTHI in IDLE
    @(negedge clk);
    @(negedge clk);
    bus.wr_lo = 1'b1; bus.wr_data = 32'h0000_ABCD;
    @(negedge clk);
    bus.wr_lo = 1'b0; bus.wr_data = 32'h0;
    check("mtlo_lo", 64'(bus.lo), 64'h0000_ABCD);
    check("mtlo_hi_kept", 64'(bus.hi), 64'h0);
    bus.wr_hi = 1'b1; bus.wr_data = 32'h0000_5555;
    @(negedge clk);
    bus.wr_hi = 1'b0; bus.wr_data = 32'h0;
    check("mthi_hi", 64'(bus.hi), 64'h0000_5555);

    // Reset at RUN cycle 10
    bus.start = 1'b1; bus.op = MD_MULTU; bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 2'b00; bus.op_a = 32'h0; bus.op_b = 32'h0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_done", 64'(bus.done), 64'h0);
    check("rst_hi",   64'(bus.hi),   64'h0);
    check("rst_lo",   64'(bus.lo),   64'h0);
    check("rst_dbz",  64'(bus.div_by_zero), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    check("rst_no_done", 64'(done_seen), 64'h0);

    // Unit is usable again after the abort
    run_op(MD_MULTU, 32'd3, 32'd4, 1'b0, lat, busy_cnt, dz_at_start);
    check("post_rst_latency", 64'(lat), 64'd33);
    check("post_rst_lo", 64'(bus.lo), 64'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
